// File: rtl/tick_stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// tick_stopwatch_bcd
//
// Avalon-MM slave stopwatch. Counts rising edges of the interval timer's
// timeout output (one edge every 100 ms) into a four-digit BCD time M:SS.T,
// drives four seven-segment displays, and provides lap capture, an alarm
// compare with a level interrupt, and a sticky wrap flag.
//
// Parameters
//   TICKS_PER_COUNT  tick edges per 0.1 s digit increment (1..255)
//   SEG_ACTIVE_LOW   1: segment outputs active-low, 0: active-high
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 STATUS, 1 CONTROL, 2 TIME, 3 LAP, 4 ALARM)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   16-bit write data
//   readdata    registered read data, valid one cycle after address
//   tick_in     timer timeout level/pulse; only rising edges count
//   irq         alarm interrupt (alarm_hit & ie), level
//   hex0..hex3  segments {g,f,e,d,c,b,a}: tenths, sec ones, sec tens, minutes
//
// Register map
//   0 STATUS  r: {13'b0, wrapped, running, alarm_hit}; any write clears flags
//   1 CONTROL r: {14'b0, ie, run}; w: run=wd[0], ie=wd[1], wd[2]=clear time
//   2 TIME    r/w: {min, sec_t, sec_o, tenth}; writes saturate per digit
//   3 LAP     r: captured time; any write captures the current TIME
//   4 ALARM   r/w: BCD compare value, saturated like a TIME write
// -----------------------------------------------------------------------------
module tick_stopwatch_bcd #(
  parameter int unsigned TICKS_PER_COUNT = 1,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        tick_in,
  output logic        irq,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  // Packed so that the field order matches the TIME register bit layout.
  typedef struct packed {
    logic [3:0] minute;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] tenth;
  } bcd_time_t;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_TIME    = 3'd2;
  localparam logic [2:0] ADDR_LAP     = 3'd3;
  localparam logic [2:0] ADDR_ALARM   = 3'd4;

  localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_COUNT - 1);

  // Active-high pattern for digit 0, converted to the output polarity.
  localparam logic [6:0] SEG_ZERO_RAW = 7'h3F;
  localparam logic [6:0] SEG_ZERO     = SEG_ACTIVE_LOW ? ~SEG_ZERO_RAW : SEG_ZERO_RAW;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Clamp each digit to its largest legal value so the counter never holds a
  // non-BCD or out-of-range digit (M <= 9, S tens <= 5, S ones <= 9, T <= 9).
  function automatic bcd_time_t bcd_saturate(input logic [15:0] raw);
    bcd_time_t v;
    v = bcd_time_t'(raw);
    if (v.minute > 4'd9) v.minute = 4'd9;
    if (v.sec_t  > 4'd5) v.sec_t  = 4'd5;
    if (v.sec_o  > 4'd9) v.sec_o  = 4'd9;
    if (v.tenth  > 4'd9) v.tenth  = 4'd9;
    return v;
  endfunction

  // Active-high {g,f,e,d,c,b,a} pattern, then the configured polarity.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] raw;
    case (digit)
      4'd0:    raw = 7'h3F;
      4'd1:    raw = 7'h06;
      4'd2:    raw = 7'h5B;
      4'd3:    raw = 7'h4F;
      4'd4:    raw = 7'h66;
      4'd5:    raw = 7'h6D;
      4'd6:    raw = 7'h7D;
      4'd7:    raw = 7'h07;
      4'd8:    raw = 7'h7F;
      4'd9:    raw = 7'h6F;
      default: raw = 7'h00;  // unreachable with saturated digits: blank
    endcase
    return SEG_ACTIVE_LOW ? ~raw : raw;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bcd_time_t  time_q;
  bcd_time_t  lap_q;
  bcd_time_t  alarm_q;
  logic [7:0] presc_q;
  logic       run_q;
  logic       ie_q;
  logic       alarm_hit_q;
  logic       wrapped_q;
  logic       tick_d;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_en;
  logic wr_status;
  logic wr_control;
  logic wr_time;
  logic wr_lap;
  logic wr_alarm;
  logic ctrl_clear;

  assign wr_en      = chipselect & ~write_n;
  assign wr_status  = wr_en & (address == ADDR_STATUS);
  assign wr_control = wr_en & (address == ADDR_CONTROL);
  assign wr_time    = wr_en & (address == ADDR_TIME);
  assign wr_lap     = wr_en & (address == ADDR_LAP);
  assign wr_alarm   = wr_en & (address == ADDR_ALARM);
  assign ctrl_clear = wr_control & writedata[2];

  // ---------------------------------------------------------------------------
  // Tick edge detection and prescaler decision
  // ---------------------------------------------------------------------------
  // tick_d follows tick_in regardless of run, so starting the watch while
  // tick_in is already high does not count a stale edge.
  logic tick_edge;
  logic count_edge;
  logic presc_hit;
  logic do_inc;

  assign tick_edge  = tick_in & ~tick_d;
  assign count_edge = tick_edge & run_q;
  assign presc_hit  = count_edge & (presc_q == PRESC_MAX);
  // A clear or a TIME write in the same cycle wins; the increment is dropped.
  assign do_inc     = presc_hit & ~ctrl_clear & ~wr_time;

  // ---------------------------------------------------------------------------
  // BCD ripple-carry increment
  // ---------------------------------------------------------------------------
  bcd_time_t time_inc;
  logic      wrap_now;

  // NOTE: every signal assigned in an always_comb gets a default on entry;
  // a path that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    time_inc = time_q;
    wrap_now = 1'b0;
    if (time_q.tenth != 4'd9) begin
      time_inc.tenth = time_q.tenth + 4'd1;
    end else begin
      time_inc.tenth = 4'd0;
      if (time_q.sec_o != 4'd9) begin
        time_inc.sec_o = time_q.sec_o + 4'd1;
      end else begin
        time_inc.sec_o = 4'd0;
        if (time_q.sec_t != 4'd5) begin
          time_inc.sec_t = time_q.sec_t + 4'd1;
        end else begin
          time_inc.sec_t = 4'd0;
          if (time_q.minute != 4'd9) begin
            time_inc.minute = time_q.minute + 4'd1;
          end else begin
            time_inc.minute = 4'd0;
            wrap_now        = 1'b1;  // 9:59.9 -> 0:00.0
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Time, prescaler and control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others (e.g. LAP captures the
  // pre-increment TIME, the alarm compare sees the old ALARM).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      time_q  <= '0;
      presc_q <= '0;
      tick_d  <= 1'b0;
      run_q   <= 1'b0;
      ie_q    <= 1'b0;
      lap_q   <= '0;
      alarm_q <= '0;
    end else begin
      tick_d <= tick_in;

      if (ctrl_clear) begin
        time_q  <= '0;
        presc_q <= '0;
      end else if (wr_time) begin
        time_q  <= bcd_saturate(writedata);
        presc_q <= '0;
      end else if (count_edge) begin
        if (presc_hit) begin
          presc_q <= '0;
          time_q  <= time_inc;
        end else begin
          presc_q <= presc_q + 8'd1;
        end
      end

      if (wr_control) begin
        run_q <= writedata[0];
        ie_q  <= writedata[1];
      end

      if (wr_lap) begin
        lap_q <= time_q;
      end

      if (wr_alarm) begin
        alarm_q <= bcd_saturate(writedata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: a STATUS write clears and beats a same-cycle set
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_hit_q <= 1'b0;
      wrapped_q   <= 1'b0;
    end else if (wr_status) begin
      alarm_hit_q <= 1'b0;
      wrapped_q   <= 1'b0;
    end else if (do_inc) begin
      // Only counting reaches the alarm; loads and clears never trigger it.
      if (time_inc == alarm_q) alarm_hit_q <= 1'b1;
      if (wrap_now)            wrapped_q   <= 1'b1;
    end
  end

  assign irq = alarm_hit_q & ie_q;

  // ---------------------------------------------------------------------------
  // Read path: registered mux, data valid the cycle after address
  // ---------------------------------------------------------------------------
  logic [15:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:  rd_mux = {13'b0, wrapped_q, run_q, alarm_hit_q};
      ADDR_CONTROL: rd_mux = {14'b0, ie_q, run_q};
      ADDR_TIME:    rd_mux = time_q;
      ADDR_LAP:     rd_mux = lap_q;
      ADDR_ALARM:   rd_mux = alarm_q;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  // ---------------------------------------------------------------------------
  // Display decode, registered: digits follow TIME one cycle later
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex0 <= SEG_ZERO;
      hex1 <= SEG_ZERO;
      hex2 <= SEG_ZERO;
      hex3 <= SEG_ZERO;
    end else begin
      hex0 <= seg_encode(time_q.tenth);
      hex1 <= seg_encode(time_q.sec_o);
      hex2 <= seg_encode(time_q.sec_t);
      hex3 <= seg_encode(time_q.minute);
    end
  end

endmodule
